// File: rtl/freq_gen_pkg.sv
// Shared types and helpers for the fractional-rate square-wave generator.
package freq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Accumulator width: must hold acc + step, which is below 2*REF_CLK_FREQ
  function automatic int unsigned acc_width(input int unsigned ref_freq);
    return $clog2(2 * longint'(ref_freq));
  endfunction

  // Highest output frequency representable: one toggle per reference cycle
  function automatic int unsigned max_freq(input int unsigned ref_freq);
    return ref_freq / 2;
  endfunction

  // Saturate a requested frequency at the representable limit
  function automatic logic [63:0] clamp_freq(input logic [63:0] freq,
                                             input logic [63:0] limit);
    return (freq > limit) ? limit : freq;
  endfunction

endpackage

// File: rtl/freq_gen_acc.sv
// Phase accumulator modulo REF_CLK_FREQ; flags a toggle whenever it wraps.
module freq_gen_acc #(
  parameter int unsigned REF_CLK_FREQ = 100_000_000,
  parameter int unsigned ACC_W        = 28
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] step,
  input  logic             run,
  input  logic             clr,
  output logic             toggle,
  output logic [ACC_W-1:0] acc
);

  localparam logic [ACC_W:0] MODULUS = (ACC_W + 1)'(REF_CLK_FREQ);

  logic [ACC_W:0] sum;

  assign sum    = {1'b0, acc} + {1'b0, step};
  assign toggle = run && (sum >= MODULUS);

  // Advance phase by step; wrap by the modulus so no rounding error accumulates
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (run) begin
      if (toggle) begin
        acc <= ACC_W'(sum - MODULUS);
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after two clock edges.
module rst_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync;

  // Shift a one through two flops so release is aligned to clk_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign rst_n_o = sync[1];

endmodule

// File: rtl/freq_gen.sv
// Fractional-rate square-wave generator. Produces clk_o with an average
// frequency of exactly cur_freq Hz from a REF_CLK_FREQ reference. Frequency
// updates arrive over valid/ready and are applied at a clk_o falling edge.
// Optional build macro FREQ_GEN_PULSE_CNT_EN adds the emitted-period counter
// on pulse_cnt_o; without it pulse_cnt_o is tied to zero.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int unsigned REF_CLK_FREQ = 100_000_000,
  parameter int unsigned FREQ_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [FREQ_WIDTH-1:0] freq_i,
  input  logic                  freq_valid_i,
  output logic                  freq_ready_o,
  output logic                  clk_o,
  output logic                  stb_o,
  output logic                  clamp_o,
  output logic [31:0]           pulse_cnt_o
);

  localparam int unsigned           ACC_W = acc_width(REF_CLK_FREQ);
  localparam logic [FREQ_WIDTH-1:0] MAX_F = FREQ_WIDTH'(max_freq(REF_CLK_FREQ));

  logic                  rst_n;
  state_t                state;
  logic [FREQ_WIDTH-1:0] cur_freq;
  logic [FREQ_WIDTH-1:0] pend_freq;
  logic [FREQ_WIDTH-1:0] freq_clamped;
  logic                  freq_over;
  logic                  accept;
  logic                  run;
  logic                  clr;
  logic                  toggle;
  logic                  rise;
  logic [ACC_W-1:0]      step;
  logic [ACC_W-1:0]      acc_phase;

  rst_sync u_rst_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .rst_n_o (rst_n)
  );

  assign accept       = freq_valid_i && freq_ready_o;
  assign freq_over    = freq_i > MAX_F;
  assign freq_clamped = FREQ_WIDTH'(clamp_freq(64'(freq_i), 64'(MAX_F)));
  assign run          = en_i && (state != IDLE);
  assign clr          = (state == IDLE);
  // Two toggles per output period, so the phase step is twice the frequency
  assign step         = ACC_W'({cur_freq, 1'b0});
  assign rise         = toggle && !clk_o;

  freq_gen_acc #(
    .REF_CLK_FREQ (REF_CLK_FREQ),
    .ACC_W        (ACC_W)
  ) u_acc (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .step   (step),
    .run    (run),
    .clr    (clr),
    .toggle (toggle),
    .acc    (acc_phase)
  );

  // Control FSM: handshake, deferred frequency update and registered outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_freq     <= '0;
      pend_freq    <= '0;
      clk_o        <= 1'b0;
      stb_o        <= 1'b0;
      clamp_o      <= 1'b0;
      freq_ready_o <= 1'b1;
    end else begin
      stb_o <= 1'b0;
      if (accept) begin
        clamp_o <= freq_over;
      end
      if (!en_i) begin
        // Disabled: park low, drop any pending update, keep cur_freq
        state        <= IDLE;
        clk_o        <= 1'b0;
        freq_ready_o <= 1'b1;
        if (accept) begin
          cur_freq <= freq_clamped;
        end
      end else begin
        if (toggle) begin
          clk_o <= ~clk_o;
        end
        stb_o <= rise;
        unique case (state)
          IDLE: begin
            if (accept) begin
              cur_freq <= freq_clamped;
            end
            freq_ready_o <= 1'b1;
            state        <= RUN;
          end
          RUN: begin
            if (accept) begin
              pend_freq    <= freq_clamped;
              freq_ready_o <= 1'b0;
              state        <= PEND;
            end
          end
          PEND: begin
            // Swap rate only as clk_o falls, or at once if the output is frozen
            if ((toggle && clk_o) || (cur_freq == '0)) begin
              cur_freq     <= pend_freq;
              freq_ready_o <= 1'b1;
              state        <= RUN;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FREQ_GEN_PULSE_CNT_EN
  logic [31:0] pulse_cnt;

  // Count emitted periods; wraps naturally and restarts whenever idle
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
    end else if (state == IDLE) begin
      pulse_cnt <= '0;
    end else if (rise) begin
      pulse_cnt <= pulse_cnt + 32'd1;
    end
  end

  assign pulse_cnt_o = pulse_cnt;
`else
  assign pulse_cnt_o = '0;
`endif

  // The wrapped phase must always stay strictly below the modulus
  acc_in_range: assert property (@(posedge clk_i) disable iff (!rst_n)
    acc_phase < ACC_W'(REF_CLK_FREQ));

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen with a 100 Hz reference modulus.
module tb_freq_gen;

  localparam int REF = 100;
  localparam int FW  = 32;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          en_i;
  logic [FW-1:0] freq_i;
  logic          freq_valid_i;
  logic          freq_ready_o;
  logic          clk_o;
  logic          stb_o;
  logic          clamp_o;
  logic [31:0]   pulse_cnt_o;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int stb_total = 0;
  int exp_q[$];

  freq_gen #(
    .REF_CLK_FREQ (REF),
    .FREQ_WIDTH   (FW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .en_i         (en_i),
    .freq_i       (freq_i),
    .freq_valid_i (freq_valid_i),
    .freq_ready_o (freq_ready_o),
    .clk_o        (clk_o),
    .stb_o        (stb_o),
    .clamp_o      (clamp_o),
    .pulse_cnt_o  (pulse_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next expected rising-edge cycle
  always @(negedge clk) begin
    if (stb_o === 1'b1) begin
      stb_total++;
      if (exp_q.size() == 0) check_eq("stb_extra", cyc, 0);
      else check_eq("stb_time", cyc, exp_q.pop_front());
    end
  end

  // Advance to just after the falling edge that follows active edge e
  task automatic wait_edge(input int e);
    do @(negedge clk); while (cyc < e);
    #1;
  endtask

  task automatic accept(input int f, output int a);
    freq_i       = FW'(f);
    freq_valid_i = 1'b1;
    a            = cyc + 1;
    wait_edge(a);
    freq_valid_i = 1'b0;
  endtask

  // Rising edge n (odd toggle index) lands at base + ceil(n*REF/(2f))
  task automatic push_rises(input int base, input int f, input int len);
    int k;
    for (int n = 1; ; n += 2) begin
      k = (n * REF + 2 * f - 1) / (2 * f);
      if (k > len) break;
      exp_q.push_back(base + k);
    end
  endtask

  task automatic stop_and_drain(input string tag);
    en_i = 1'b0;
    wait_edge(cyc + 2);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_idle_clk"}, clk_o, 0);
    exp_q.delete();
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef FREQ_GEN_PULSE_CNT_EN
    return 32'(n);
`else
    return (n == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  initial begin
    int a;
    int w0;
    rst_n_i      = 1'b0;
    en_i         = 1'b0;
    freq_i       = '0;
    freq_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_clk", clk_o, 0);
    check_eq("rst_stb", stb_o, 0);
    check_eq("rst_clamp", clamp_o, 0);
    check_eq("rst_ready", freq_ready_o, 1);
    check_eq("rst_cnt", pulse_cnt_o, 0);
    rst_n_i = 1'b1;
    wait_edge(cyc + 3);

    // 25 Hz: period 4, 2 high / 2 low, 25 strobes per 100 cycles
    en_i = 1'b1;
    accept(25, a);
    check_eq("clamp25", clamp_o, 0);
    push_rises(a, 25, 100);
    w0 = stb_total;
    for (int k = 1; k <= 100; k++) begin
      wait_edge(a + k);
      if (k <= 16) check_eq("clk25", clk_o, ((2 * 25 * k) / REF) % 2);
    end
    check_eq("win25", stb_total - w0, 25);
    check_eq("cnt25", pulse_cnt_o, cnt_exp(25));
    stop_and_drain("run25");

    // Re-enable without a new request: restart from zero phase at 25 Hz
    en_i = 1'b1;
    a = cyc + 1;
    push_rises(a, 25, 20);
    wait_edge(a + 20);
    check_eq("cnt_restart", pulse_cnt_o, cnt_exp(5));
    stop_and_drain("restart");

    // 30 Hz: exactly 30 strobes in every 100-cycle window, no drift
    en_i = 1'b1;
    accept(30, a);
    push_rises(a, 30, 10000);
    w0 = stb_total;
    for (int j = 1; j <= 100; j++) begin
      wait_edge(a + 100 * j);
      check_eq("win30", stb_total - w0, 30);
      w0 = stb_total;
    end
    check_eq("cnt30", pulse_cnt_o, cnt_exp(3000));
    stop_and_drain("run30");

    // 60 Hz is clamped to 50: toggle every cycle; then 10 Hz clears clamp
    en_i = 1'b1;
    accept(60, a);
    check_eq("clamp60", clamp_o, 1);
    push_rises(a, 50, 20);
    for (int k = 1; k <= 6; k++) begin
      wait_edge(a + k);
      check_eq("clk50", clk_o, k % 2);
    end
    wait_edge(a + 20);
    stop_and_drain("run50");
    accept(10, a);
    check_eq("clamp10", clamp_o, 0);

    // Running at 25, request 10 while high: applied at the next fall
    en_i = 1'b1;
    accept(25, a);
    exp_q.push_back(a + 2);
    push_rises(a + 4, 10, 40);
    wait_edge(a + 2);
    check_eq("chg_high", clk_o, 1);
    freq_i       = FW'(10);
    freq_valid_i = 1'b1;
    wait_edge(a + 3);
    freq_valid_i = 1'b0;
    check_eq("chg_ready_pend", freq_ready_o, 0);
    check_eq("chg_still_high", clk_o, 1);
    wait_edge(a + 4);
    check_eq("chg_ready_back", freq_ready_o, 1);
    check_eq("chg_fall", clk_o, 0);
    wait_edge(a + 9);
    check_eq("chg_rise10", clk_o, 1);
    wait_edge(a + 13);
    check_eq("chg_high10", clk_o, 1);
    wait_edge(a + 14);
    check_eq("chg_fall10", clk_o, 0);
    wait_edge(a + 44);
    stop_and_drain("chg");

    // 0 Hz: frozen low; a following request applies one cycle later
    en_i = 1'b1;
    accept(0, a);
    wait_edge(a + 10);
    check_eq("zero_clk", clk_o, 0);
    freq_i       = FW'(25);
    freq_valid_i = 1'b1;
    wait_edge(a + 11);
    freq_valid_i = 1'b0;
    check_eq("zero_ready_pend", freq_ready_o, 0);
    push_rises(a + 12, 25, 20);
    wait_edge(a + 12);
    check_eq("zero_ready_back", freq_ready_o, 1);
    wait_edge(a + 32);
    stop_and_drain("zero");

    // Asynchronous reset in the high phase drops everything at once
    en_i = 1'b1;
    accept(25, a);
    exp_q.push_back(a + 2);
    wait_edge(a + 2);
    check_eq("pre_rst_high", clk_o, 1);
    check_eq("pre_rst_cnt", pulse_cnt_o, cnt_exp(1));
    rst_n_i = 1'b0;
    #1;
    check_eq("arst_clk", clk_o, 0);
    check_eq("arst_stb", stb_o, 0);
    check_eq("arst_cnt", pulse_cnt_o, 0);
    check_eq("arst_ready", freq_ready_o, 1);
    wait_edge(cyc + 2);
    rst_n_i = 1'b1;
    wait_edge(cyc + 6);
    check_eq("post_rst_clk", clk_o, 0);
    check_eq("post_rst_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
